product_accumulator: RTL and testbench
======================================

// Module: product_accumulator
// PURPOSE
//  Downstream consumer of the 4x4 array multiplier's 8-bit product.
//  Sums a frame of COUNT consecutive products into one ACC_W-bit result.
//  Hands the sum onward on a valid/ready output, with an overflow indication.
//  Adds the sequential stage (beat counting, frame framing, back-pressure) that the
//  combinational multiplier lacks, e.g. for dot products on the tile's 8-bit output bus.
// PARAMETERS
//  PROD_W  8   width of each incoming product
//  ACC_W   10  accumulator/result width; PROD_W+clog2(COUNT) avoids overflow
//  COUNT   4   products per frame, legal range 1..16
// PORTS
//  clk           in   1       single clock, all state on rising edge
//  rst           in   1       synchronous, active-high reset
//  clear         in   1       synchronous frame flush, one-cycle pulse
//  prod_valid    in   1       product beat present
//  prod_data     in   PROD_W  unsigned product
//  prod_ready    out  1       block accepts a beat this cycle
//  acc_valid     out  1       frame sum available
//  acc_data      out  ACC_W   frame sum
//  acc_overflow  out  1       sum exceeded 2^ACC_W-1 during this frame
//  acc_ready     in   1       downstream takes the sum
// BEHAVIOUR
//  Clock and reset: one clock (clk); rst is synchronous and active-high.
//  Reset (rst=1 at posedge): state=ACCUM, acc=0, cnt=0, ovf=0.
//    Outputs after reset: prod_ready=1, acc_valid=0, acc_data=0, acc_overflow=0.
//  FSM states:
//    ACCUM: prod_ready=1, acc_valid=0.
//      Beat = prod_valid&prod_ready: acc<=acc+zext(prod_data), cnt<=cnt+1.
//      Beat with cnt==COUNT-1 -> DONE next cycle; final sum includes that beat.
//    DONE: prod_ready=0, acc_valid=1.
//      acc_data/acc_overflow held stable until acc_ready=1.
//      acc_valid&acc_ready -> acc=0, cnt=0, ovf=0, back to ACCUM next cycle.
//      No beat is accepted in the handoff cycle.
//  Latency: acc_valid rises the cycle after the last beat is accepted.
//  Throughput: at best COUNT+1 cycles per frame.
//  acc_data is a registered output and equals the running acc in every state.
//  prod_ready is a function of state only; no combinational path from acc_ready.
//  Arithmetic: sum computed ACC_W+1 wide; bit ACC_W set -> ovf<=1 (sticky to end of frame).
//  clear=1: acc=0, cnt=0, ovf=0, state=ACCUM.
//    Any beat or handoff in that same cycle is discarded.
//    Priority: rst > clear > beat/handoff.
//  COUNT=1: every accepted beat goes straight to DONE.
//  cnt is clog2(COUNT)+1 bits and never wraps; it is cleared on each handoff.
//  prod_valid while in DONE: ignored, because prod_ready=0; upstream holds its data.
//  prod_data is sampled only on a beat; X values outside beats have no effect.
// CONFIGURATION
//  PRODUCT_ACC_SAT_EN defined: on overflow, acc clamps to 2^ACC_W-1 and stays there.
//    ovf is still set.
//  PRODUCT_ACC_SAT_EN undefined: acc wraps modulo 2^ACC_W; ovf flags the wrap.
// STRUCTURE
//  Package product_acc_pkg holds:
//    state enum {ACCUM, DONE};
//    CNT_W = $clog2(COUNT)+1;
//    localparam SAT_MAX = {ACC_W{1'b1}}.
//  One natural sub-module: acc_adder.
//    Combinational ACC_W+1 adder plus saturate/wrap mux; the only place the macro is tested.
//  The FSM, counter and output registers sit in the top module.
// TESTING
//  T1 defaults, 4 beats of 8'hE1 back-to-back
//    -> acc_valid in cycle 5, acc_data=10'h384, ovf=0.
//  T2 acc_ready held low 3 cycles in DONE, prod_valid=1 throughout
//    -> data stable, prod_ready=0, no beat counted.
//    Then release -> next frame starts from 0.
//  T3 ACC_W=9, 4 beats of 8'hFF
//    -> SAT_EN: acc_data=9'h1FF, ovf=1.
//    -> no SAT_EN: acc_data=9'h1FC (1020 mod 512), ovf=1.
//  T4 2 beats of 8'h10, then clear coincident with a third beat, then 4 beats of 8'h01
//    -> acc_data=10'h004.
//  T5 rst asserted in DONE with acc_ready=1
//    -> next cycle acc_valid=0, acc_data=0, prod_ready=1.
//  T6 COUNT=1, prod_valid toggling every cycle with 8'h07, acc_ready=1
//    -> alternating sums of 7, one beat every 2 cycles.

Source files
------------

// File: rtl/product_accumulator_pkg.sv
// ---------------------------------------------------------------------------
// product_acc_pkg
// Purpose : shared types and helpers for the product accumulator slice.
//           - state_e   : frame FSM states (ACCUM collects beats, DONE offers sum)
//           - cnt_width : beat-counter width for a given COUNT ($clog2(COUNT)+1)
//           - default parameter values used by the top and its interface
// Config  : PRODUCT_ACC_SAT_EN is tested only in acc_adder.
// ---------------------------------------------------------------------------
package product_acc_pkg;

   typedef enum logic {
      ACCUM = 1'b0,
      DONE  = 1'b1
   } state_e;

   localparam int PROD_W_DEF = 8;
   localparam int ACC_W_DEF  = 10;
   localparam int COUNT_DEF  = 4;

   // Counter is one bit wider than needed to index COUNT beats so it never wraps.
   function automatic int cnt_width(input int count);
      return $clog2(count) + 1;
   endfunction

   localparam int CNT_W_DEF = cnt_width(COUNT_DEF);

endpackage

// File: rtl/product_accumulator_if.sv
// ---------------------------------------------------------------------------
// product_accumulator_if
// Purpose : product input stream and frame-sum output stream of the accumulator.
// Signals : prod_valid/prod_data/prod_ready  - incoming product beats
//           acc_valid/acc_data/acc_overflow/acc_ready - outgoing frame sum
// Modports: master - environment side (drives products, takes sums)
//           slave  - accumulator side
// ---------------------------------------------------------------------------
interface product_accumulator_if #(
   parameter int PROD_W = 8,
   parameter int ACC_W  = 10
);
   logic              prod_valid;
   logic [PROD_W-1:0] prod_data;
   logic              prod_ready;
   logic              acc_valid;
   logic [ACC_W-1:0]  acc_data;
   logic              acc_overflow;
   logic              acc_ready;

   modport master (
      output prod_valid, prod_data, acc_ready,
      input  prod_ready, acc_valid, acc_data, acc_overflow
   );

   modport slave (
      input  prod_valid, prod_data, acc_ready,
      output prod_ready, acc_valid, acc_data, acc_overflow
   );
endinterface

// File: rtl/product_accumulator_acc_adder.sv
// ---------------------------------------------------------------------------
// acc_adder
// Purpose : combinational accumulate step. Adds a zero-extended product to the
//           running sum one bit wider than the accumulator; the extra bit is the
//           overflow indication.
// Config  : PRODUCT_ACC_SAT_EN defined   -> sum clamps to all-ones on overflow
//           PRODUCT_ACC_SAT_EN undefined -> sum wraps modulo 2^ACC_W
// Ports   : acc_i  [ACC_W]  current running sum
//           prod_i [PROD_W] product to add
//           sum_o  [ACC_W]  next running sum
//           ovf_o  [1]      carry out of bit ACC_W-1
// ---------------------------------------------------------------------------
module acc_adder #(
   parameter int PROD_W = 8,
   parameter int ACC_W  = 10
) (
   input  logic [ACC_W-1:0]  acc_i,
   input  logic [PROD_W-1:0] prod_i,
   output logic [ACC_W-1:0]  sum_o,
   output logic              ovf_o
);

   localparam logic [ACC_W-1:0] SAT_MAX = '1;

   logic [ACC_W:0] wide_sum;

   assign wide_sum = {1'b0, acc_i} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_i};
   assign ovf_o    = wide_sum[ACC_W];

`ifdef PRODUCT_ACC_SAT_EN
   // Once clamped, every further add overflows again, so the sum stays at SAT_MAX.
   assign sum_o = wide_sum[ACC_W] ? SAT_MAX : wide_sum[ACC_W-1:0];
`else
   assign sum_o = wide_sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/product_accumulator.sv
// ---------------------------------------------------------------------------
// product_accumulator
// Purpose : sums a frame of COUNT consecutive products and hands the sum
//           onward with valid/ready, plus a sticky per-frame overflow flag.
// Config  : PRODUCT_ACC_SAT_EN selects saturating (defined) or wrapping
//           (undefined) accumulation; see acc_adder.
// Ports   : clk   - single clock, rising edge
//           rst   - synchronous active-high reset (highest priority)
//           clear - synchronous frame flush; discards a same-cycle beat/handoff
//           bus   - product_accumulator_if.slave (product in, sum out)
// ---------------------------------------------------------------------------
module product_accumulator
   import product_acc_pkg::*;
#(
   parameter int PROD_W = PROD_W_DEF,
   parameter int ACC_W  = ACC_W_DEF,
   parameter int COUNT  = COUNT_DEF
) (
   input logic                  clk,
   input logic                  rst,
   input logic                  clear,
   product_accumulator_if.slave bus
);

   localparam int CNT_W = cnt_width(COUNT);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(COUNT - 1);

   state_e             state_q;
   logic [ACC_W-1:0]   acc_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               ovf_q;
   logic               prod_ready_q;
   logic               acc_valid_q;

   logic [ACC_W-1:0]   sum_d;
   logic               ovf_d;
   logic               beat;

   acc_adder #(
      .PROD_W (PROD_W),
      .ACC_W  (ACC_W)
   ) u_acc_adder (
      .acc_i  (acc_q),
      .prod_i (bus.prod_data),
      .sum_o  (sum_d),
      .ovf_o  (ovf_d)
   );

   // prod_ready_q mirrors the state register, so a beat never depends on acc_ready.
   assign beat = bus.prod_valid & prod_ready_q;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         state_q      <= ACCUM;
         acc_q        <= '0;
         cnt_q        <= '0;
         ovf_q        <= 1'b0;
         prod_ready_q <= 1'b1;
         acc_valid_q  <= 1'b0;
      end else begin
         unique case (state_q)
            ACCUM: begin
               if (beat) begin
                  acc_q <= sum_d;
                  ovf_q <= ovf_q | ovf_d;
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (cnt_q == LAST_BEAT) begin
                     state_q      <= DONE;
                     prod_ready_q <= 1'b0;
                     acc_valid_q  <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (bus.acc_ready) begin
                  state_q      <= ACCUM;
                  acc_q        <= '0;
                  cnt_q        <= '0;
                  ovf_q        <= 1'b0;
                  prod_ready_q <= 1'b1;
                  acc_valid_q  <= 1'b0;
               end
            end
            default: begin
               state_q      <= ACCUM;
               prod_ready_q <= 1'b1;
               acc_valid_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.prod_ready   = prod_ready_q;
   assign bus.acc_valid    = acc_valid_q;
   assign bus.acc_data     = acc_q;
   assign bus.acc_overflow = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// ---------------------------------------------------------------------------
// tb_product_accumulator
// Purpose : directed self-checking bench for product_accumulator.
//           Three instances share clk/rst:
//             u_def  - defaults (PROD_W=8, ACC_W=10, COUNT=4)
//             u_w9   - ACC_W=9 for overflow behaviour
//             u_c1   - COUNT=1 single-beat frames
// ---------------------------------------------------------------------------
module tb_product_accumulator;

   logic clk = 1'b0;
   logic rst;
   logic clr_def, clr_w9, clr_c1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   product_accumulator_if #(.PROD_W(8), .ACC_W(10)) bus_def ();
   product_accumulator_if #(.PROD_W(8), .ACC_W(9))  bus_w9 ();
   product_accumulator_if #(.PROD_W(8), .ACC_W(10)) bus_c1 ();

   product_accumulator #(.PROD_W(8), .ACC_W(10), .COUNT(4)) u_def (
      .clk (clk), .rst (rst), .clear (clr_def), .bus (bus_def)
   );
   product_accumulator #(.PROD_W(8), .ACC_W(9), .COUNT(4)) u_w9 (
      .clk (clk), .rst (rst), .clear (clr_w9), .bus (bus_w9)
   );
   product_accumulator #(.PROD_W(8), .ACC_W(10), .COUNT(1)) u_c1 (
      .clk (clk), .rst (rst), .clear (clr_c1), .bus (bus_c1)
   );

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

`ifdef PRODUCT_ACC_SAT_EN
   localparam logic [15:0] W9_AFTER3 = 16'h1FF;
   localparam logic [15:0] W9_FINAL  = 16'h1FF;
`else
   localparam logic [15:0] W9_AFTER3 = 16'h0FD;
   localparam logic [15:0] W9_FINAL  = 16'h1FC;
`endif

   initial begin
      rst = 1'b1;
      clr_def = 1'b0; clr_w9 = 1'b0; clr_c1 = 1'b0;
      bus_def.prod_valid = 1'b0; bus_def.prod_data = '0; bus_def.acc_ready = 1'b0;
      bus_w9.prod_valid  = 1'b0; bus_w9.prod_data  = '0; bus_w9.acc_ready  = 1'b0;
      bus_c1.prod_valid  = 1'b0; bus_c1.prod_data  = '0; bus_c1.acc_ready  = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      chk("rst_prod_ready", 16'(bus_def.prod_ready), 16'h1);
      chk("rst_acc_valid",  16'(bus_def.acc_valid), 16'h0);
      chk("rst_acc_data",   16'(bus_def.acc_data), 16'h0);
      chk("rst_ovf",        16'(bus_def.acc_overflow), 16'h0);

      // T1: four back-to-back beats of E1
      bus_def.prod_valid = 1'b1; bus_def.prod_data = 8'hE1;
      tick(); tick(); tick();
      chk("t1_valid_b3", 16'(bus_def.acc_valid), 16'h0);
      chk("t1_data_b3",  16'(bus_def.acc_data), 16'h2A3);
      tick();
      chk("t1_valid", 16'(bus_def.acc_valid), 16'h1);
      chk("t1_data",  16'(bus_def.acc_data), 16'h384);
      chk("t1_ovf",   16'(bus_def.acc_overflow), 16'h0);
      chk("t1_ready", 16'(bus_def.prod_ready), 16'h0);

      // T2: back-pressure in DONE with prod_valid held high
      bus_def.prod_data = 8'h55;
      for (int unsigned i = 0; i < 3; i++) begin
         tick();
         chk("t2_hold_data",  16'(bus_def.acc_data), 16'h384);
         chk("t2_hold_valid", 16'(bus_def.acc_valid), 16'h1);
         chk("t2_hold_ready", 16'(bus_def.prod_ready), 16'h0);
      end
      bus_def.acc_ready = 1'b1;
      tick();
      chk("t2_hs_valid", 16'(bus_def.acc_valid), 16'h0);
      chk("t2_hs_data",  16'(bus_def.acc_data), 16'h0);
      chk("t2_hs_ready", 16'(bus_def.prod_ready), 16'h1);
      bus_def.acc_ready = 1'b0;
      tick();
      chk("t2_new_frame", 16'(bus_def.acc_data), 16'h055);
      bus_def.prod_valid = 1'b0;

      // Flush the partial frame
      clr_def = 1'b1;
      tick();
      clr_def = 1'b0;
      chk("clr_flush", 16'(bus_def.acc_data), 16'h0);

      // T4: two beats, clear coincident with a third, then four beats of 01
      bus_def.prod_valid = 1'b1; bus_def.prod_data = 8'h10;
      tick(); tick();
      chk("t4_pre_clear", 16'(bus_def.acc_data), 16'h020);
      clr_def = 1'b1;
      tick();
      clr_def = 1'b0;
      chk("t4_clear_data",  16'(bus_def.acc_data), 16'h0);
      chk("t4_clear_ready", 16'(bus_def.prod_ready), 16'h1);
      bus_def.prod_data = 8'h01;
      tick(); tick(); tick();
      chk("t4_valid_b3", 16'(bus_def.acc_valid), 16'h0);
      tick();
      bus_def.prod_valid = 1'b0;
      chk("t4_valid", 16'(bus_def.acc_valid), 16'h1);
      chk("t4_data",  16'(bus_def.acc_data), 16'h004);

      // T3: ACC_W=9, four beats of FF
      bus_w9.prod_valid = 1'b1; bus_w9.prod_data = 8'hFF;
      tick(); tick();
      chk("t3_data_b2", 16'(bus_w9.acc_data), 16'h1FE);
      chk("t3_ovf_b2",  16'(bus_w9.acc_overflow), 16'h0);
      tick();
      chk("t3_data_b3", 16'(bus_w9.acc_data), W9_AFTER3);
      chk("t3_ovf_b3",  16'(bus_w9.acc_overflow), 16'h1);
      tick();
      bus_w9.prod_valid = 1'b0;
      chk("t3_valid", 16'(bus_w9.acc_valid), 16'h1);
      chk("t3_data",  16'(bus_w9.acc_data), W9_FINAL);
      chk("t3_ovf",   16'(bus_w9.acc_overflow), 16'h1);
      bus_w9.acc_ready = 1'b1;
      tick();
      bus_w9.acc_ready = 1'b0;
      chk("t3_ovf_cleared", 16'(bus_w9.acc_overflow), 16'h0);
      chk("t3_data_cleared", 16'(bus_w9.acc_data), 16'h0);

      // T6: COUNT=1, prod_valid toggling, acc_ready held high
      bus_c1.acc_ready = 1'b1; bus_c1.prod_data = 8'h07;
      for (int unsigned i = 0; i < 6; i++) begin
         bus_c1.prod_valid = (i % 2 == 0);
         tick();
         chk("t6_valid", 16'(bus_c1.acc_valid), (i % 2 == 0) ? 16'h1 : 16'h0);
         chk("t6_data",  16'(bus_c1.acc_data), (i % 2 == 0) ? 16'h7 : 16'h0);
      end
      bus_c1.prod_valid = 1'b0;

      // T5: reset while in DONE with acc_ready high (u_def is in DONE from T4)
      chk("t5_pre_valid", 16'(bus_def.acc_valid), 16'h1);
      bus_def.acc_ready = 1'b1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus_def.acc_ready = 1'b0;
      chk("t5_valid", 16'(bus_def.acc_valid), 16'h0);
      chk("t5_data",  16'(bus_def.acc_data), 16'h0);
      chk("t5_ready", 16'(bus_def.prod_ready), 16'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
